// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter (optional perf counters via CDB_PERF_EN)
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_value,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value
`ifdef CDB_PERF_EN
  ,
  output logic [N_REQ*CNT_W-1:0]    stall_cnt
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W:0]    probe;
  logic              grant_any;
  logic [N_REQ-1:0]  grant;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_value;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;

  // Round-robin search starting at rr_ptr; reset and flush both suppress any grant.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    winner    = '0;
    probe     = '0;
    if (rst && !flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        probe = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (probe >= (PTR_W+1)'(N_REQ)) probe = probe - (PTR_W+1)'(N_REQ);
        if (!grant_any && req_valid[probe[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          winner    = probe[PTR_W-1:0];
        end
      end
      if (grant_any) grant[winner] = 1'b1;
    end
  end

  assign req_ready = grant;

  // Select the granted source's tag and value from the packed request buses.
  always_comb begin
    win_tag   = '0;
    win_value = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_tag   = req_tag[i*TAG_W +: TAG_W];
        win_value = req_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer and broadcast; tag 0 is consumed but never broadcast, payload holds when idle.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_valid_d = grant_any && (win_tag != '0);
    if (grant_any) begin
      rr_ptr_d    = (winner == PTR_W'(N_REQ-1)) ? '0 : winner + PTR_W'(1);
      cdb_tag_d   = win_tag;
      cdb_value_d = win_value;
    end
  end

  // State register; reset has priority over flush and discards any in-flight grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;

`ifdef CDB_PERF_EN
  logic [CNT_W-1:0] stall_q [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    // Saturating count of cycles this source waited while the bus was not flushed.
    always_ff @(posedge clk) begin
      if (!rst) begin
        stall_q[g] <= '0;
      end else if (req_valid[g] && !grant[g] && !flush && (stall_q[g] != '1)) begin
        stall_q[g] <= stall_q[g] + CNT_W'(1);
      end
    end
    assign stall_cnt[g*CNT_W +: CNT_W] = stall_q[g];
  end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) among the completing execution sources: ALU reservation station, CMP reservation station and load-store buffer.
- Grants at most one requester per cycle using round-robin.
- Registers the winning {ROB tag, value} onto the CDB, where the ROB, register file and all reservation stations snoop it.
- Sits between execution-unit outputs and the ROB/RS wake-up logic.

Parameters:
- N_REQ, 3, number of requesting sources (index 0=ALU, 1=CMP, 2=LSB); legal 2..8.
- TAG_W, 4, ROB tag width; tag 0 is reserved as "no tag".
- DATA_W, 32, result width.
- CNT_W, 16, width of each perf counter (only used with CDB_PERF_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- flush  in  1  pipeline flush (mispredict); suppresses grants and broadcast.
- req_valid  in  N_REQ  per-source result pending.
- req_tag  in  N_REQ*TAG_W  per-source ROB tag; source i occupies bits [i*TAG_W +: TAG_W].
- req_value  in  N_REQ*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  combinational grant, one-hot or zero; source i may retire its entry at this edge.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_value  out  DATA_W  registered broadcast value.
- stall_cnt  out  N_REQ*CNT_W  per-source count of cycles valid-but-not-granted (only with CDB_PERF_EN).

Behaviour:
- Reset (rst=0 at edge): cdb_valid=0, cdb_tag=0, cdb_value=0, rr_ptr=0, stall_cnt all 0. req_ready=0 whenever rst=0.
- Handshake:
  - Source holds valid/tag/value stable until req_ready is seen high.
  - Transfer occurs on the edge where req_valid[i] & req_ready[i].
  - req_ready never asserts for a source with req_valid=0.
- Arbitration (combinational):
  - Search indices rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - The first index with req_valid=1 is the winner; req_ready[winner]=1, all others 0.
  - No valid requests -> req_ready=0.
- rr_ptr update:
  - On a grant, rr_ptr <= (winner+1) mod N_REQ; wrap from N_REQ-1 to 0.
  - No grant -> rr_ptr holds.
- Broadcast, 1-cycle latency from grant:
  - cdb_valid <= grant & (winner tag != 0).
  - cdb_tag/cdb_value <= winner's tag/value on a grant; otherwise hold the previous value.
  - cdb_valid is a single-cycle pulse per transfer; back-to-back grants give back-to-back pulses.
- Tag 0 request: still granted (consumed and removed from the source) but never broadcast (cdb_valid=0 that cycle). This prevents deadlock on malformed entries.
- Flush=1:
  - req_ready=0 for all sources.
  - cdb_valid <= 0 at that edge.
  - rr_ptr holds.
  - cdb_tag/cdb_value hold.
  - A broadcast already registered in the cycle flush rises remains visible for that cycle only.
- Flush and reset together: reset wins.
- Reset mid-transfer: the grant is discarded; the source must re-present after reset.
- Fairness: a continuously-valid source is granted within N_REQ cycles of raising valid, absent flush.

Optional Feature:
- Macro CDB_PERF_EN.
- Defined:
  - stall_cnt port present.
  - Per source: counter increments by 1 each cycle with req_valid[i]=1, req_ready[i]=0 and flush=0.
  - Counter saturates at all-ones.
  - Counters are cleared only by reset.
- Undefined: stall_cnt port and counters are absent; arbitration and broadcast timing are identical.

Test Plan:
- Reset, then a single request: rst=0 for 2 cycles -> all outputs 0. Then rst=1 and req_valid=3'b001, tag=5, value=32'hDEAD_BEEF -> req_ready=3'b001 the same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_value=32'hDEAD_BEEF; the cycle after, cdb_valid=0.
- All three held valid with tags 1/2/3 from rr_ptr=0 -> grants 001, 010, 100 on consecutive cycles; cdb_tag 1, 2, 3 on cycles +1..+3; rr_ptr wraps to 0.
- Rotation fairness: source 0 continuously valid and source 2 valid starting one cycle after source 0's first grant -> next grant goes to source 2 before source 0 is granted again.
- Flush: three sources valid and flush=1 for 2 cycles -> req_ready=0, cdb_valid=0 during the flush. After flush, grant order resumes from the saved rr_ptr.
- Tag 0 drop: source 1 valid with tag 0 -> req_ready=3'b010; next cycle cdb_valid=0; rr_ptr advances to 2.
- CDB_PERF_EN: sources 0 and 1 valid together for 2 cycles from rr_ptr=0 -> stall_cnt[1]=1 and stall_cnt[0]=0 after cycle 1. With CNT_W=2, a source held stalled for 5 cycles reads 3 (saturated).
